layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Top-level inference sequencer for the neural-network datapath. For each layer in turn, it starts the RAM read driver with the layer index and waits for that driver's end-of-load `sum_trigger`. It then starts the accumulate/activation stage and waits for its completion pulse. After the last layer it signals pass completion, and a watchdog flags a stuck handshake.

## Interface
Parameters:
- `NUM_LAYERS`, default 3: layers per pass; legal range 1..4.
- `TIMEOUT`, default 255: maximum cycles spent in any wait state; legal range 1..255.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- `run`  in  1  level request; sampled only in IDLE.
- `abort`  in  1  cancels the current pass from any non-IDLE state.
- `ld_start`  out  1  one-cycle start pulse to the read driver.
- `ld_layer`  out  2  layer index to the read driver; stable from `ld_start` until the next layer.
- `ld_sum_trigger`  in  1  from the read driver; high for 2 consecutive cycles at end of load.
- `acc_start`  out  1  one-cycle start pulse to the accumulate stage.
- `acc_done`  in  1  one-cycle completion pulse from the accumulate stage.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `done`  out  1  one-cycle pulse at the end of a full pass.
- `err`  out  1  sticky timeout flag.
- `pass_count`  out  8  number of completed passes; wraps.

## Operation
- All outputs are registered. Reset values: `ld_start`, `acc_start`, `busy`, `done` and `err` are 0; `ld_layer` is 0; `pass_count` is 0; the state is IDLE.
- States and transitions:
  - IDLE: `run`=1 moves to LOAD_START, sets layer to 0 and clears `err`.
  - LOAD_START: `ld_start`=1 for one cycle, then LOAD_WAIT.
  - LOAD_WAIT: a rising edge on `ld_sum_trigger` moves to ACC_START. The second high cycle of `ld_sum_trigger` is ignored.
  - ACC_START: `acc_start`=1 for one cycle, then ACC_WAIT.
  - ACC_WAIT: `acc_done`=1 moves to NEXT.
  - NEXT: if layer == `NUM_LAYERS`-1, go to DONE; otherwise increment layer and go to LOAD_START.
  - DONE: `done`=1 and `pass_count`+1, then IDLE. If `run` is still high, IDLE starts a new pass on the following cycle.
  - ERROR: `err`=1, `busy`=0. Leaves to IDLE only when `run`=0.
- Edge detect: a rising edge is `ld_sum_trigger` & ~registered previous value. The previous-value register is updated in every state.
- Watchdog:
  - Clears on entry to LOAD_WAIT and ACC_WAIT and increments each cycle in those states.
  - When it reaches `TIMEOUT` with no event, the FSM goes to ERROR.
- Priority, highest first: `reset`, then `abort`, then handshake event, then timeout.
  - An event arriving in the same cycle as the timeout is accepted; no error is raised.
- `abort`: moves to IDLE next cycle. No `done`, `pass_count` unchanged, `ld_layer` returns to 0, `err` unchanged.
- `acc_done` or a `ld_sum_trigger` edge arriving outside its wait state is ignored.
- `pass_count` wraps from 255 to 0.

## Timing
- `run` high in IDLE at cycle n gives `ld_start`=1 at n+1, with `ld_layer` valid at n+1.
- `ld_sum_trigger` rising at m gives `acc_start`=1 at m+1.
- `acc_done` at k:
  - NEXT at k+1.
  - For a non-final layer: `ld_start` at k+2.
  - For the final layer: `done` at k+2, IDLE at k+3.
- Minimum gap from a `ld_sum_trigger` edge to the next `ld_start` is 4 cycles. This guarantees the read driver has returned to its idle state.
- Timeout fires in the cycle after the counter equals `TIMEOUT`. Example: `TIMEOUT`=255 and no `acc_done` gives ERROR 256 cycles after entering ACC_WAIT.

## Structure
- Shared package `nn_seq_pkg`:
  - State enum: IDLE, LOAD_START, LOAD_WAIT, ACC_START, ACC_WAIT, NEXT, DONE, ERROR.
  - Layer index width of 2.
  - Default `NUM_LAYERS` and `TIMEOUT` constants.
- Sub-module `seq_watchdog`: clear/enable/expire counter parameterised by `TIMEOUT`, same `clk`/`reset`.
- Everything else is flat in `layer_sequencer`.

## Test plan
- Reset mid-pass, then idle: all outputs 0, `pass_count`=0, no `ld_start` for 10 cycles with `run`=0.
- `NUM_LAYERS`=3, responder models the read driver (2-cycle `sum_trigger` 12 cycles after start) and `acc_done` 5 cycles after `acc_start`:
  - `ld_layer` sequence is 0, 1, 2.
  - Exactly 3 `ld_start` and 3 `acc_start` pulses, one `done`, `pass_count`=1, `busy` falls 1 cycle after `done`.
- `run` held high for 2 passes: second `ld_start` (layer 0) 2 cycles after first `done`; `pass_count`=2.
- Withhold `acc_done` with `TIMEOUT`=8:
  - ERROR 9 cycles after ACC_WAIT entry; `err`=1, `busy`=0.
  - Stays in ERROR while `run`=1; goes to IDLE after `run`=0; next accepted `run` clears `err`.
- `abort` in the same cycle as a `ld_sum_trigger` edge on layer 1: no `acc_start`, IDLE next cycle, `ld_layer`=0, no `done`.
- `acc_done` in the same cycle as timeout expiry: NEXT taken, `err` stays 0. Also preload `pass_count`=255 via 255 passes; the next `done` wraps it to 0.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the inference layer sequencer.
//   - state encoding for the layer_sequencer FSM
//   - layer index width and watchdog counter width
//   - default NUM_LAYERS / TIMEOUT values
package nn_seq_pkg;

  localparam int LAYER_W        = 2;
  localparam int WD_W           = 8;
  localparam int DEF_NUM_LAYERS = 3;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_START,
    LOAD_WAIT,
    ACC_START,
    ACC_WAIT,
    NEXT,
    DONE,
    ERROR
  } seq_state_e;

  // States in which the sequencer is blocked on an external handshake.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == LOAD_WAIT) || (s == ACC_WAIT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Handshake watchdog for the layer sequencer.
//   clk, reset : clock / synchronous active-high reset
//   clr_i      : zero the counter (entry into a wait state)
//   en_i       : count this cycle (sitting in a wait state)
//   expired_o  : counter has reached TIMEOUT
// The counter holds at TIMEOUT so it can never wrap back to a
// non-expired value while the FSM lingers.
module seq_watchdog
  import nn_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Top-level inference sequencer. Per layer: pulse ld_start with the
// layer index, wait for the read driver's sum_trigger edge, pulse
// acc_start, wait for acc_done. After the last layer pulse done and
// bump pass_count. A watchdog sends the FSM to ERROR if a handshake
// stalls.
//   clk, reset      : clock / synchronous active-high reset
//   run             : level start request, looked at only in IDLE
//   abort           : drop the current pass, back to IDLE
//   ld_start/ld_layer, ld_sum_trigger : read driver handshake
//   acc_start, acc_done               : accumulate stage handshake
//   busy, done, err, pass_count       : status
// Every output is a flop; the output decode works on the next state so
// registered outputs line up with the state they belong to.
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               abort,
  output logic               ld_start,
  output logic [LAYER_W-1:0] ld_layer,
  input  logic               ld_sum_trigger,
  output logic               acc_start,
  input  logic               acc_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         pass_count
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  seq_state_e         state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               trig_q;
  logic               err_q, err_d;
  logic [7:0]         pc_q, pc_d;
  logic               ld_start_q, ld_start_d;
  logic               acc_start_q, acc_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic sum_rise;
  logic wd_clr, wd_en, wd_expired;
  logic abort_hit;

  // The driver holds sum_trigger for two cycles; only the first counts.
  assign sum_rise  = ld_sum_trigger & ~trig_q;
  assign abort_hit = abort && (state_q != IDLE);

  // Restart on entry to a wait state, count while sitting in one.
  assign wd_clr = is_wait_state(state_d) && (state_d != state_q);
  assign wd_en  = is_wait_state(state_q);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // State register (plus the registered outputs and datapath state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      trig_q      <= 1'b0;
      err_q       <= 1'b0;
      pc_q        <= '0;
      ld_start_q  <= 1'b0;
      acc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      trig_q      <= ld_sum_trigger;
      err_q       <= err_d;
      pc_q        <= pc_d;
      ld_start_q  <= ld_start_d;
      acc_start_q <= acc_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic. Abort beats any handshake event, and a handshake
  // event beats a watchdog expiry landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (run) state_d = LOAD_START;
        LOAD_START: state_d = LOAD_WAIT;
        LOAD_WAIT: begin
          if (sum_rise)        state_d = ACC_START;
          else if (wd_expired) state_d = ERROR;
        end
        ACC_START:  state_d = ACC_WAIT;
        ACC_WAIT: begin
          if (acc_done)        state_d = NEXT;
          else if (wd_expired) state_d = ERROR;
        end
        NEXT:       state_d = (layer_q == LAST_LAYER) ? DONE : LOAD_START;
        DONE:       state_d = IDLE;
        ERROR:      if (!run) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values, decoded from the upcoming state.
  always_comb begin
    ld_start_d  = (state_d == LOAD_START);
    acc_start_d = (state_d == ACC_START);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE) && (state_d != ERROR);

    layer_d = layer_q;
    if (abort_hit)
      layer_d = '0;
    else if (state_q == IDLE && state_d == LOAD_START)
      layer_d = '0;
    else if (state_q == NEXT && state_d == LOAD_START)
      layer_d = layer_q + 1'b1;

    // err is sticky: only a newly accepted run clears it.
    err_d = err_q;
    if (state_d == ERROR)
      err_d = 1'b1;
    else if (state_q == IDLE && state_d == LOAD_START)
      err_d = 1'b0;

    pc_d = pc_q;
    if (state_d == DONE)
      pc_d = pc_q + 8'd1;
  end

  assign ld_start   = ld_start_q;
  assign ld_layer   = layer_q;
  assign acc_start  = acc_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pass_count = pc_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults, driven by a read-driver / accumulator responder.
  logic       run_a, abort_a, trig_a, accd_a;
  logic       ld_start_a, acc_start_a, busy_a, done_a, err_a;
  logic [1:0] ld_layer_a;
  logic [7:0] pc_a;

  // Instance B: TIMEOUT=8, driven by hand for the watchdog corners.
  logic       run_b, abort_b, trig_b, accd_b;
  logic       ld_start_b, acc_start_b, busy_b, done_b, err_b;
  logic [1:0] ld_layer_b;
  logic [7:0] pc_b;

  layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .run(run_a), .abort(abort_a),
    .ld_start(ld_start_a), .ld_layer(ld_layer_a), .ld_sum_trigger(trig_a),
    .acc_start(acc_start_a), .acc_done(accd_a),
    .busy(busy_a), .done(done_a), .err(err_a), .pass_count(pc_a));

  layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .abort(abort_b),
    .ld_start(ld_start_b), .ld_layer(ld_layer_b), .ld_sum_trigger(trig_b),
    .acc_start(acc_start_b), .acc_done(accd_b),
    .busy(busy_b), .done(done_b), .err(err_b), .pass_count(pc_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected ld_layer values, pushed when a pass is requested.
  int exp_layer_q[$];

  // Responder for A.
  int ld_dly = 12, acc_dly = 5;
  int ls = -1000, as_ = -1000;
  initial begin
    trig_a = 1'b0;
    accd_a = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_start_a)  ls  = cyc;
      if (acc_start_a) as_ = cyc;
      trig_a = (cyc == ls + ld_dly) || (cyc == ls + ld_dly + 1);
      accd_a = (cyc == as_ + acc_dly);
    end
  end

  // Monitor for A.
  int cnt_ld = 0, cnt_acc = 0, cnt_done = 0;
  int last_done = 0, gap = -1;
  bit after_done = 0, done_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        done_prev = 0;
      end else begin
        if (ld_start_a) begin
          cnt_ld++;
          if (exp_layer_q.size() == 0) chk("unexpected_ld_start", 1, 0);
          else chk("ld_layer", int'(ld_layer_a), exp_layer_q.pop_front());
          if (after_done) begin
            gap = cyc - last_done;
            after_done = 0;
          end
        end
        if (acc_start_a) cnt_acc++;
        if (done_prev) chk("busy_after_done", int'(busy_a), 0);
        if (done_a) begin
          cnt_done++;
          last_done = cyc;
          after_done = 1;
          chk("busy_at_done", int'(busy_a), 1);
        end
        done_prev = done_a;
      end
    end
  end

  task automatic push_passes(input int passes);
    for (int p = 0; p < passes; p++)
      for (int l = 0; l < 3; l++) exp_layer_q.push_back(l);
  endtask

  task automatic run_passes(input int passes);
    int k = 0;
    int budget = passes * 300 + 50;
    run_a = 1'b1;
    while (k < passes && budget > 0) begin
      @(negedge clk);
      budget--;
      if (done_a) k++;
    end
    run_a = 1'b0;
    if (k < passes) chk("pass_wait_expired", k, passes);
  endtask

  typedef struct {
    int ld_dly;
    int acc_dly;
    int passes;
    int exp_ld;
    int exp_acc;
    int exp_done;
    int exp_gap;
  } vec_t;

  vec_t tbl[4];
  int exp_pc = 0;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c0, a0, d0, s1, budget;
    bit found;

    tbl[0] = '{12, 5, 1, 3, 3, 1, -1};
    tbl[1] = '{12, 5, 2, 6, 6, 2,  2};
    tbl[2] = '{ 1, 1, 1, 3, 3, 1, -1};
    tbl[3] = '{ 3, 7, 2, 6, 6, 2,  2};

    reset = 1'b1;
    run_a = 0; abort_a = 0;
    run_b = 0; abort_b = 0; trig_b = 0; accd_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_ld_start",  int'(ld_start_a),  0);
    chk("rst_acc_start", int'(acc_start_a), 0);
    chk("rst_busy",      int'(busy_a),      0);
    chk("rst_done",      int'(done_a),      0);
    chk("rst_err",       int'(err_a),       0);
    chk("rst_ld_layer",  int'(ld_layer_a),  0);
    chk("rst_pass_count", int'(pc_a),       0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven full passes on A.
    for (int v = 0; v < 4; v++) begin
      ld_dly  = tbl[v].ld_dly;
      acc_dly = tbl[v].acc_dly;
      c0 = cnt_ld; a0 = cnt_acc; d0 = cnt_done;
      push_passes(tbl[v].passes);
      run_passes(tbl[v].passes);
      repeat (5) @(negedge clk);
      chk("ld_start_count",  cnt_ld - c0,   tbl[v].exp_ld);
      chk("acc_start_count", cnt_acc - a0,  tbl[v].exp_acc);
      chk("done_count",      cnt_done - d0, tbl[v].exp_done);
      exp_pc += tbl[v].passes;
      chk("pass_count", int'(pc_a), exp_pc % 256);
      chk("scoreboard_empty", exp_layer_q.size(), 0);
      chk("idle_busy", int'(busy_a), 0);
      if (tbl[v].exp_gap >= 0) chk("restart_gap", gap, tbl[v].exp_gap);
    end

    // Reset mid-pass, then stay idle.
    ld_dly = 12; acc_dly = 5;
    push_passes(1);
    run_a = 1'b1; @(negedge clk); run_a = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("mrst_ld_start",  int'(ld_start_a),  0);
    chk("mrst_acc_start", int'(acc_start_a), 0);
    chk("mrst_busy",      int'(busy_a),      0);
    chk("mrst_done",      int'(done_a),      0);
    chk("mrst_err",       int'(err_a),       0);
    chk("mrst_ld_layer",  int'(ld_layer_a),  0);
    chk("mrst_pass_count", int'(pc_a),       0);
    exp_pc = 0;
    exp_layer_q.delete();
    c0 = cnt_ld;
    repeat (10) @(negedge clk);
    chk("idle_no_ld_start", cnt_ld - c0, 0);
    chk("idle_busy_after_reset", int'(busy_a), 0);

    // Abort coinciding with the layer-1 sum_trigger edge.
    ld_dly = 12; acc_dly = 5;
    push_passes(1);
    run_a = 1'b1; @(negedge clk); run_a = 1'b0;
    found = 0; budget = 200;
    while (!found && budget > 0) begin
      if (ld_start_a && ld_layer_a == 2'd1) found = 1;
      else begin @(negedge clk); budget--; end
    end
    if (!found) chk("abort_wait_layer1_expired", 0, 1);
    s1 = cyc; a0 = cnt_acc; d0 = cnt_done;
    while (cyc < s1 + ld_dly) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy",      int'(busy_a),      0);
    chk("abort_ld_layer",  int'(ld_layer_a),  0);
    chk("abort_acc_start", int'(acc_start_a), 0);
    repeat (8) @(negedge clk);
    chk("abort_no_acc_start", cnt_acc - a0,  0);
    chk("abort_no_done",      cnt_done - d0, 0);
    chk("abort_pass_count",   int'(pc_a),    exp_pc);
    chk("abort_err",          int'(err_a),   0);
    exp_layer_q.delete();

    // Timeout on B: withhold acc_done.
    run_b = 1'b1; @(negedge clk);            // LOAD_START
    run_b = 1'b0;
    chk("b_ld_start", int'(ld_start_b), 1);
    @(negedge clk);                          // LOAD_WAIT
    trig_b = 1'b1; @(negedge clk);           // ACC_START
    chk("b_acc_start", int'(acc_start_b), 1);
    @(negedge clk);                          // ACC_WAIT entry
    trig_b = 1'b0;
    repeat (8) @(negedge clk);               // counter == TIMEOUT
    chk("b_pre_timeout_err",  int'(err_b),  0);
    chk("b_pre_timeout_busy", int'(busy_b), 1);
    @(negedge clk);                          // 9 cycles after entry
    chk("b_timeout_err",  int'(err_b),  1);
    chk("b_timeout_busy", int'(busy_b), 0);
    run_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold_err",      int'(err_b),      1);
      chk("b_hold_ld_start", int'(ld_start_b), 0);
    end
    run_b = 1'b0; @(negedge clk);            // IDLE
    chk("b_idle_err_sticky", int'(err_b),  1);
    chk("b_idle_busy",       int'(busy_b), 0);
    run_b = 1'b1; @(negedge clk);            // LOAD_START
    run_b = 1'b0;
    chk("b_restart_ld_start", int'(ld_start_b), 1);
    chk("b_restart_err_clr",  int'(err_b),      0);
    abort_b = 1'b1; @(negedge clk);
    abort_b = 1'b0;
    chk("b_abort_busy", int'(busy_b), 0);

    // acc_done / sum_trigger landing exactly on the expiry cycle.
    run_b = 1'b1; @(negedge clk);
    run_b = 1'b0; @(negedge clk);            // LOAD_WAIT
    trig_b = 1'b1; @(negedge clk);           // ACC_START
    @(negedge clk);                          // ACC_WAIT entry
    trig_b = 1'b0;
    repeat (8) @(negedge clk);
    accd_b = 1'b1; @(negedge clk);           // NEXT
    accd_b = 1'b0;
    chk("b_race_next_err",  int'(err_b),  0);
    chk("b_race_next_busy", int'(busy_b), 1);
    @(negedge clk);                          // LOAD_START, layer 1
    chk("b_race_ld_start", int'(ld_start_b), 1);
    chk("b_race_ld_layer", int'(ld_layer_b), 1);
    repeat (9) @(negedge clk);               // LOAD_WAIT, counter == TIMEOUT
    trig_b = 1'b1; @(negedge clk);
    chk("b_race_trig_acc_start", int'(acc_start_b), 1);
    chk("b_race_trig_err",       int'(err_b),       0);
    abort_b = 1'b1; @(negedge clk);
    abort_b = 1'b0; trig_b = 1'b0;
    chk("b_race_abort_busy",  int'(busy_b),     0);
    chk("b_race_abort_layer", int'(ld_layer_b), 0);

    // pass_count wrap on A.
    ld_dly = 1; acc_dly = 1;
    push_passes(255);
    run_passes(255);
    repeat (3) @(negedge clk);
    exp_pc = (exp_pc + 255) % 256;
    chk("pass_count_255", int'(pc_a), exp_pc);
    push_passes(1);
    run_passes(1);
    repeat (3) @(negedge clk);
    exp_pc = (exp_pc + 1) % 256;
    chk("pass_count_wrap", int'(pc_a), exp_pc);
    chk("wrap_scoreboard_empty", exp_layer_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
